ascon_sigma_unit: RTL and testbench

ASCON_SIGMA_UNIT -- requirements
Module: ascon_sigma_unit

---
 rtl/ascon_pkg.sv | 44 ++++
 rtl/ascon_ror.sv | 22 ++
 rtl/ascon_sigma_unit.sv | 159 +++++++++++++++
 tb/tb_ascon_sigma_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon sigma (linear diffusion) unit:
// per-lane rotation pairs, FSM state encoding and parameter legality checks.
package ascon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROT0,
    ST_ROT1,
    ST_DONE
  } sigma_state_e;

  typedef struct packed {
    logic [5:0] r0;
    logic [5:0] r1;
  } rot_pair_t;

  localparam int unsigned NUM_LANES = 5;

  // Right-rotate amounts applied to each of the five state lanes.
  localparam rot_pair_t ROT_TABLE [NUM_LANES] = '{
    '{r0: 6'd19, r1: 6'd28},
    '{r0: 6'd61, r1: 6'd39},
    '{r0: 6'd1,  r1: 6'd6 },
    '{r0: 6'd10, r1: 6'd17},
    '{r0: 6'd7,  r1: 6'd41}
  };

  function automatic logic lane_bad(input logic [4:0] imm);
    return imm > 5'(NUM_LANES - 1);
  endfunction

  // Out-of-range lanes map to a zero rotation pair; the result is masked anyway.
  function automatic rot_pair_t rot_lookup(input logic [4:0] imm);
    rot_pair_t p;
    p = '0;
    if (!lane_bad(imm)) p = ROT_TABLE[imm[2:0]];
    return p;
  endfunction

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/ascon_ror.sv
// Parametrised logarithmic right-rotator.
module ascon_ror #(
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage;

  // One conditional power-of-two rotate per shift-amount bit.
  always_comb begin
    stage = din;
    for (int unsigned s = 0; s < SHW; s++) begin
      if (amt[s]) stage = (stage >> (2 ** s)) | (stage << (WIDTH - 2 ** s));
    end
    dout = stage;
  end

endmodule

// File: rtl/ascon_sigma_unit.sv
// Ascon sigma unit: rd = x ^ ror(x,r0) ^ ror(x,r1) for a selected lane.
// XLEN=64 works on a full lane; XLEN=32 works on a bit-interleaved lane
// split into even (rs1) and odd (rs2) halves. SERIAL=1 time-shares a
// single rotator over two cycles.
module ascon_sigma_unit
  import ascon_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned SERIAL = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      imm,
  input  logic            op_sigma,
  input  logic            op_hi,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [XLEN-1:0] rd,
  output logic            rd_err
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("ascon_sigma_unit: XLEN must be 32 or 64");
  end

  localparam int unsigned  NROT     = (SERIAL != 0) ? 1 : 2;
  localparam sigma_state_e FIRST_ST = (SERIAL != 0) ? ST_ROT0 : ST_DONE;

  sigma_state_e    state_q, state_d;
  logic            accept;
  logic [63:0]     lane_in, lane_q;
  logic [4:0]      imm_q;
  logic            sigma_q, hi_q;
  rot_pair_t       rp;
  logic [5:0]      rot_amt [NROT];
  logic [63:0]     rot_out [NROT];
  logic [63:0]     res_lane;
  logic [XLEN-1:0] res_word;

  assign accept = op_valid && op_ready;
  assign rp     = rot_lookup(imm_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: an accept in DONE restarts exactly as an accept in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = FIRST_ST;
      ST_ROT0: state_d = ST_ROT1;
      ST_ROT1: state_d = ST_DONE;
      ST_DONE: begin
        if (accept)        state_d = FIRST_ST;
        else if (rd_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture on acceptance only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q  <= '0;
      imm_q   <= '0;
      sigma_q <= 1'b0;
      hi_q    <= 1'b0;
    end else if (accept) begin
      lane_q  <= lane_in;
      imm_q   <= imm;
      sigma_q <= op_sigma;
      hi_q    <= op_hi;
    end
  end

  if (SERIAL != 0) begin : g_amt_serial
    assign rot_amt[0] = (state_q == ST_ROT1) ? rp.r1 : rp.r0;
  end else begin : g_amt_par
    assign rot_amt[0] = rp.r0;
    assign rot_amt[1] = rp.r1;
  end

  for (genvar gi = 0; gi < NROT; gi++) begin : g_rot
    if (XLEN == 64) begin : g_x64
      ascon_ror #(.WIDTH(64)) u_ror (
        .din  (lane_q),
        .amt  (rot_amt[gi]),
        .dout (rot_out[gi])
      );
    end else begin : g_x32
      // ror64 by 2k rotates both halves by k; by 2k+1 swaps halves,
      // rotating the new even half by k and the new odd half by k+1.
      logic        odd;
      logic [4:0]  k, od_amt;
      logic [31:0] ev_in, od_in, ev_out, od_out;

      assign odd    = rot_amt[gi][0];
      assign k      = rot_amt[gi][5:1];
      assign od_amt = k + {4'b0, odd};
      assign ev_in  = odd ? lane_q[63:32] : lane_q[31:0];
      assign od_in  = odd ? lane_q[31:0]  : lane_q[63:32];

      ascon_ror #(.WIDTH(32)) u_ror_ev (
        .din  (ev_in),
        .amt  (k),
        .dout (ev_out)
      );
      ascon_ror #(.WIDTH(32)) u_ror_od (
        .din  (od_in),
        .amt  (od_amt),
        .dout (od_out)
      );

      assign rot_out[gi] = {od_out, ev_out};
    end
  end

  if (SERIAL != 0) begin : g_acc
    logic [63:0] acc_q;

    // Accumulate x ^ ror(x,r0) in ROT0, then fold in ror(x,r1) in ROT1.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                     acc_q <= '0;
      else if (state_q == ST_ROT0) acc_q <= lane_q ^ rot_out[0];
      else if (state_q == ST_ROT1) acc_q <= acc_q ^ rot_out[0];
    end

    assign res_lane = acc_q;
  end else begin : g_par
    assign res_lane = lane_q ^ rot_out[0] ^ rot_out[1];
  end

  if (XLEN == 64) begin : g_io64
    logic unused_x32;
    assign lane_in    = rs1;
    assign res_word   = res_lane;
    assign unused_x32 = ^{rs2, hi_q};
  end else begin : g_io32
    assign lane_in  = {rs2, rs1};
    assign res_word = hi_q ? res_lane[63:32] : res_lane[31:0];
  end

  // Handshake and result outputs; result fields are zero unless valid.
  always_comb begin
    op_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && rd_ready);
    rd_valid = (state_q == ST_DONE);
    rd_err   = rd_valid && lane_bad(imm_q);
    rd       = '0;
    if (rd_valid && sigma_q && !lane_bad(imm_q)) rd = res_word;
  end

endmodule

// File: tb/tb_ascon_sigma_unit.sv
// Scoreboard bench for ascon_sigma_unit in three configurations:
// dut0 = XLEN 64 parallel, dut1 = XLEN 64 serial, dut2 = XLEN 32 parallel.
module tb_ascon_sigma_unit;

  localparam int ND = 3;

  typedef struct {
    int          d;
    logic [63:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid [ND];
  logic        op_sigma [ND];
  logic        op_hi    [ND];
  logic        rd_ready [ND];
  logic [63:0] rs1      [ND];
  logic [63:0] rs2      [ND];
  logic [4:0]  imm      [ND];
  logic        op_ready [ND];
  logic        rd_valid [ND];
  logic        rd_err   [ND];
  logic [63:0] rd64     [2];
  logic [31:0] rd32;

  exp_t sb[$];
  int   res_cyc0[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ascon_sigma_unit #(.XLEN(64), .SERIAL(0)) u_p64 (
    .clk(clk), .rst(rst), .op_valid(op_valid[0]), .op_ready(op_ready[0]),
    .rs1(rs1[0]), .rs2(rs2[0]), .imm(imm[0]), .op_sigma(op_sigma[0]),
    .op_hi(op_hi[0]), .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]),
    .rd(rd64[0]), .rd_err(rd_err[0])
  );

  ascon_sigma_unit #(.XLEN(64), .SERIAL(1)) u_s64 (
    .clk(clk), .rst(rst), .op_valid(op_valid[1]), .op_ready(op_ready[1]),
    .rs1(rs1[1]), .rs2(rs2[1]), .imm(imm[1]), .op_sigma(op_sigma[1]),
    .op_hi(op_hi[1]), .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]),
    .rd(rd64[1]), .rd_err(rd_err[1])
  );

  ascon_sigma_unit #(.XLEN(32), .SERIAL(0)) u_p32 (
    .clk(clk), .rst(rst), .op_valid(op_valid[2]), .op_ready(op_ready[2]),
    .rs1(rs1[2][31:0]), .rs2(rs2[2][31:0]), .imm(imm[2]), .op_sigma(op_sigma[2]),
    .op_hi(op_hi[2]), .rd_valid(rd_valid[2]), .rd_ready(rd_ready[2]),
    .rd(rd32), .rd_err(rd_err[2])
  );

  function automatic logic [63:0] rd_of(input int d);
    if (d == 2) return {32'h0, rd32};
    return rd64[d[0]];
  endfunction

  task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %h expected %h", d, nm, act, exp);
    end
  endtask

  // Monitor: pop the oldest expectation for a DUT whenever it hands over a result.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < ND; d++) begin
        if (rd_valid[d] && rd_ready[d]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].d == d) begin
              idx = i;
              break;
            end
          end
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected_result: got rd=%h err=%0b expected none", d, rd_of(d), rd_err[d]);
          end else begin
            chk(d, "rd", rd_of(d), sb[idx].rd);
            chk(d, "rd_err", 64'(rd_err[d]), 64'(sb[idx].err));
            sb.delete(idx);
            if (d == 0) res_cyc0.push_back(cyc);
          end
        end else if (!rd_valid[d]) begin
          chk(d, "idle_zero", rd_of(d) | 64'(rd_err[d]), 64'h0);
        end
      end
    end
  end

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] im, input logic sg, input logic hi,
                       input logic [63:0] e_rd, input logic e_err, input int lat);
    int n;
    rs1[d] = a; rs2[d] = b; imm[d] = im; op_sigma[d] = sg; op_hi[d] = hi;
    op_valid[d] = 1'b1;
    #1;
    n = 0;
    while (!op_ready[d] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!op_ready[d]) begin
      checks++;
      errors++;
      $display("FAIL dut%0d accept_timeout: got op_ready=0 expected 1", d);
      op_valid[d] = 1'b0;
      return;
    end
    sb.push_back('{d: d, rd: e_rd, err: e_err});
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the captured request must be unaffected.
    op_valid[d] = 1'b0;
    rs1[d] = ~a; rs2[d] = ~b; imm[d] = ~im; op_sigma[d] = ~sg; op_hi[d] = ~hi;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk(d, "latency", 64'(rd_valid[d]), 64'(i == lat));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      op_valid[d] = 1'b0; op_sigma[d] = 1'b0; op_hi[d] = 1'b0; rd_ready[d] = 1'b1;
      rs1[d] = '0; rs2[d] = '0; imm[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk(d, "reset_rd_valid", 64'(rd_valid[d]), 64'h0);
      chk(d, "reset_rd", rd_of(d) | 64'(rd_err[d]), 64'h0);
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) chk(d, "reset_op_ready", 64'(op_ready[d]), 64'h1);
    settle();

    // XLEN=64 parallel: one-cycle latency, refill back-to-back from DONE.
    issue(0, 64'h1, 64'h0, 5'd0, 1'b1, 1'b0, 64'h0000_2010_0000_0001, 1'b0, 1);
    issue(0, 64'h1, 64'h0, 5'd2, 1'b1, 1'b0, 64'h8400_0000_0000_0001, 1'b0, 1);
    issue(0, 64'h1, 64'h0, 5'd3, 1'b1, 1'b0, 64'h0040_8000_0000_0001, 1'b0, 1);
    issue(0, 64'h1, 64'h0, 5'd4, 1'b1, 1'b0, 64'h0200_0000_0080_0001, 1'b0, 1);
    issue(0, 64'h8000_0000_0000_0000, 64'h0, 5'd1, 1'b1, 1'b0, 64'h8000_0000_0100_0004, 1'b0, 1);
    issue(0, '1, 64'h0, 5'd0, 1'b1, 1'b0, '1, 1'b0, 1);
    issue(0, '1, 64'h0, 5'd5, 1'b1, 1'b0, 64'h0, 1'b1, 1);
    issue(0, 64'h1, 64'h0, 5'd0, 1'b0, 1'b0, 64'h0, 1'b0, 1);
    issue(0, 64'h1, 64'h0, 5'd7, 1'b0, 1'b0, 64'h0, 1'b1, 1);
    issue(0, '1, 64'h0, 5'd31, 1'b1, 1'b0, 64'h0, 1'b1, 1);
    settle();

    // Backpressure: result must hold for three cycles with op_ready low.
    rd_ready[0] = 1'b0;
    issue(0, 64'h1, 64'h0, 5'd1, 1'b1, 1'b0, 64'h0000_0000_0200_0009, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      chk(0, "hold_rd", rd_of(0), 64'h0000_0000_0200_0009);
      chk(0, "hold_valid", 64'(rd_valid[0]), 64'h1);
      chk(0, "hold_op_ready", 64'(op_ready[0]), 64'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rd_ready[0] = 1'b1;
    settle();

    // Four back-to-back requests must produce four consecutive results.
    res_cyc0.delete();
    for (int k = 0; k < 4; k++) begin
      logic [63:0] ev;
      case (k)
        0: ev = 64'h0000_2010_0000_0001;
        1: ev = 64'h0000_0000_0200_0009;
        2: ev = 64'h8400_0000_0000_0001;
        default: ev = 64'h0040_8000_0000_0001;
      endcase
      rs1[0] = 64'h1; imm[0] = 5'(k); op_sigma[0] = 1'b1; op_valid[0] = 1'b1;
      #1;
      chk(0, "burst_op_ready", 64'(op_ready[0]), 64'h1);
      sb.push_back('{d: 0, rd: ev, err: 1'b0});
      @(posedge clk);
      #1;
    end
    op_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk(0, "burst_count", 64'(res_cyc0.size()), 64'd4);
    if (res_cyc0.size() == 4) chk(0, "burst_span", 64'(res_cyc0[3] - res_cyc0[0]), 64'd3);
    settle();

    // XLEN=64 serial: three-cycle latency.
    issue(1, 64'h1, 64'h0, 5'd1, 1'b1, 1'b0, 64'h0000_0000_0200_0009, 1'b0, 3);
    issue(1, 64'h1, 64'h0, 5'd0, 1'b1, 1'b0, 64'h0000_2010_0000_0001, 1'b0, 3);
    issue(1, 64'h1, 64'h0, 5'd2, 1'b1, 1'b0, 64'h8400_0000_0000_0001, 1'b0, 3);
    issue(1, 64'h1, 64'h0, 5'd4, 1'b1, 1'b0, 64'h0200_0000_0080_0001, 1'b0, 3);
    issue(1, 64'h8000_0000_0000_0000, 64'h0, 5'd1, 1'b1, 1'b0, 64'h8000_0000_0100_0004, 1'b0, 3);
    issue(1, '1, 64'h0, 5'd6, 1'b1, 1'b0, 64'h0, 1'b1, 3);
    issue(1, 64'h1, 64'h0, 5'd3, 1'b0, 1'b0, 64'h0, 1'b0, 3);
    settle();

    // Reset while dut1 sits in ROT0: request dropped, no result produced.
    rs1[1] = 64'h1; imm[1] = 5'd1; op_sigma[1] = 1'b1; op_valid[1] = 1'b1;
    #1;
    chk(1, "rst_pre_ready", 64'(op_ready[1]), 64'h1);
    @(posedge clk);
    #1;
    op_valid[1] = 1'b0;
    #2;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk(1, "rst_rd_valid", 64'(rd_valid[1]), 64'h0);
    end
    rst = 1'b0;
    #1;
    chk(1, "rst_release_ready", 64'(op_ready[1]), 64'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(1, "rst_no_result", 64'(rd_valid[1]), 64'h0);
    end
    settle();
    issue(1, 64'h1, 64'h0, 5'd1, 1'b1, 1'b0, 64'h0000_0000_0200_0009, 1'b0, 3);
    settle();

    // XLEN=32 interleaved halves.
    issue(2, 64'h1, 64'h0, 5'd2, 1'b1, 1'b0, 64'h2000_0001, 1'b0, 1);
    issue(2, 64'h1, 64'h0, 5'd2, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 1);
    issue(2, 64'h1, 64'h0, 5'd0, 1'b1, 1'b0, 64'h0004_0001, 1'b0, 1);
    issue(2, 64'h1, 64'h0, 5'd0, 1'b1, 1'b1, 64'h0040_0000, 1'b0, 1);
    issue(2, 64'h0, 64'h1, 5'd1, 1'b1, 1'b0, 64'h0000_2004, 1'b0, 1);
    issue(2, 64'h0, 64'h1, 5'd1, 1'b1, 1'b1, 64'h0000_0001, 1'b0, 1);
    issue(2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd3, 1'b1, 1'b0, 64'hFFFF_FFFF, 1'b0, 1);
    issue(2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd5, 1'b1, 1'b1, 64'h0, 1'b1, 1);
    issue(2, 64'h1, 64'h0, 5'd2, 1'b0, 1'b0, 64'h0, 1'b0, 1);
    settle();

    chk(0, "scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
